alu_issue_sequencer: RTL and testbench

// Drives the master ALU. Accepts 32-bit instruction words over a valid/ready handshake and decodes them.

---
 rtl/alu_issue_sequencer_pkg.sv | 66 ++++++
 rtl/alu_issue_sequencer_cond_eval.sv | 37 +++
 rtl/alu_issue_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_issue_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_sequencer_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, condition
// codes, flag bit positions, FSM states and the instruction word layout.
package alu_issue_sequencer_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LSR  = 4'h6;
    localparam logic [3:0] OP_LSL  = 4'h7;
    localparam logic [3:0] OP_ROR  = 4'h8;
    localparam logic [3:0] OP_MOV  = 4'h9;
    localparam logic [3:0] OP_MOVN = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;

    localparam logic [3:0] CC_AL = 4'h0;
    localparam logic [3:0] CC_EQ = 4'h1;
    localparam logic [3:0] CC_GT = 4'h2;
    localparam logic [3:0] CC_LT = 4'h3;
    localparam logic [3:0] CC_GE = 4'h4;
    localparam logic [3:0] CC_LE = 4'h5;
    localparam logic [3:0] CC_HI = 4'h6;
    localparam logic [3:0] CC_CC = 4'h7;
    localparam logic [3:0] CC_CS = 4'h8;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] cond;
        logic [3:0] op;
        logic       s;
        logic [3:0] rd;
        logic [3:0] rn;
        logic [3:0] rm;
        logic [4:0] shamt;
        logic [5:0] rsvd;
    } instr_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_CMP;
    endfunction

    // Shifts and CMP always set flags; moves never do, even with S=1.
    function automatic logic op_upd_flags(input logic [3:0] op,
                                          input logic       s);
        logic is_mov;
        logic forced;
        is_mov = (op == OP_MOV) || (op == OP_MOVN);
        forced = (op == OP_LSR) || (op == OP_LSL) ||
                 (op == OP_ROR) || (op == OP_CMP);
        return !is_mov && (s || forced);
    endfunction

endpackage

// File: rtl/alu_issue_sequencer_cond_eval.sv
// Condition-code evaluator: cond_i against flags_i {N,Z,C,V} -> pass_o.
// Purely combinational; codes 1001-1111 never pass.
module alu_cond_eval
    import alu_issue_sequencer_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags_i[FLG_N];
    assign z = flags_i[FLG_Z];
    assign c = flags_i[FLG_C];
    assign v = flags_i[FLG_V];

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            CC_AL:   pass_o = 1'b1;
            CC_EQ:   pass_o = z;
            CC_GT:   pass_o = !z && (n == v);
            CC_LT:   pass_o = (n != v);
            CC_GE:   pass_o = (n == v);
            CC_LE:   pass_o = z || (n != v);
            CC_HI:   pass_o = c && !z;
            CC_CC:   pass_o = !c;
            CC_CS:   pass_o = c;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_sequencer.sv
// Issue sequencer for the master ALU: accepts an instruction, reads the
// register file, holds operands on the ALU, then writes result/NZCV back.
// Ports: instr_* handshake in, rf_* register-file side, alu_* to/from the
// combinational ALU, flags (architectural NZCV), done/illegal retire pulses.
module alu_issue_sequencer
    import alu_issue_sequencer_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int NREG        = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    input  logic [31:0] instr_data,
    output logic        instr_ready,
    output logic [3:0]  rf_raddr1,
    output logic [3:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] alu_reg1,
    output logic [31:0] alu_reg2,
    output logic [4:0]  alu_iv_shft,
    output logic [15:0] alu_iv_mov,
    output logic [3:0]  alu_opcode,
    output logic [3:0]  alu_cond,
    output logic        alu_s,
    output logic [3:0]  alu_flag,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_new_flag,
    output logic [3:0]  flags,
    output logic        done,
    output logic        illegal
);

    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_CYCLES - 1);

    state_e      state_q, state_d;
    instr_t      instr_q, instr_d;
    logic [31:0] reg1_q, reg1_d;
    logic [31:0] reg2_q, reg2_d;
    logic        pass_q, pass_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] res_q, res_d;
    logic [3:0]  nflg_q, nflg_d;
    logic [3:0]  flags_q, flags_d;

    logic [31:0] instr_raw;
    logic        cond_pass;
    logic        legal;
    logic        commit;
    logic        rd_ok;

    alu_cond_eval u_cond (
        .cond_i  (instr_q.cond),
        .flags_i (flags_q),
        .pass_o  (cond_pass)
    );

    assign instr_raw = instr_q;
    assign legal     = op_legal(instr_q.op);
    assign commit    = pass_q && legal;
    // Writes to addresses beyond the populated register file are dropped.
    assign rd_ok     = ({28'd0, instr_q.rd} < 32'(NREG));

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        reg1_d      = reg1_q;
        reg2_d      = reg2_q;
        pass_d      = pass_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        nflg_d      = nflg_q;
        flags_d     = flags_q;
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    instr_d = instr_t'(instr_data);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                reg1_d  = rf_rdata1;
                reg2_d  = rf_rdata2;
                // Condition is judged against flags as they stand now.
                pass_d  = cond_pass;
                cnt_d   = CNT_LOAD;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    res_d   = alu_result;
                    nflg_d  = alu_new_flag;
                    state_d = ST_WB;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_WB: begin
                done    = 1'b1;
                illegal = !legal;
                if (commit) begin
                    rf_we = (instr_q.op != OP_CMP) && rd_ok;
                    if (op_upd_flags(instr_q.op, instr_q.s)) begin
                        flags_d = nflg_q;
                    end
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            reg1_q  <= '0;
            reg2_q  <= '0;
            pass_q  <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            nflg_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            reg1_q  <= reg1_d;
            reg2_q  <= reg2_d;
            pass_q  <= pass_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            nflg_q  <= nflg_d;
            flags_q <= flags_d;
        end
    end

    assign rf_raddr1   = instr_q.rn;
    assign rf_raddr2   = instr_q.rm;
    assign rf_waddr    = instr_q.rd;
    assign rf_wdata    = res_q;
    assign alu_reg1    = reg1_q;
    assign alu_reg2    = reg2_q;
    assign alu_iv_shft = instr_q.shamt;
    assign alu_iv_mov  = instr_raw[15:0];
    assign alu_opcode  = instr_q.op;
    // The ALU always computes; conditional gating happens here.
    assign alu_cond    = 4'b0000;
    assign alu_s       = instr_q.s || (instr_q.op == OP_CMP);
    assign alu_flag    = flags_q;
    assign flags       = flags_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a behavioural RF and ALU.
// Hand-computed results, flags, latency and handshake spacing are checked.
module tb_alu_issue_sequencer;
    import alu_issue_sequencer_pkg::*;

    localparam int EC = 3;

    logic        clk;
    logic        reset_n;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        instr_ready;
    logic [3:0]  rf_raddr1;
    logic [3:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] alu_reg1;
    logic [31:0] alu_reg2;
    logic [4:0]  alu_iv_shft;
    logic [15:0] alu_iv_mov;
    logic [3:0]  alu_opcode;
    logic [3:0]  alu_cond;
    logic        alu_s;
    logic [3:0]  alu_flag;
    logic [31:0] alu_result;
    logic [3:0]  alu_new_flag;
    logic [3:0]  flags;
    logic        done;
    logic        illegal;

    alu_issue_sequencer #(.EXEC_CYCLES(EC), .NREG(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr_valid  (instr_valid),
        .instr_data   (instr_data),
        .instr_ready  (instr_ready),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .alu_reg1     (alu_reg1),
        .alu_reg2     (alu_reg2),
        .alu_iv_shft  (alu_iv_shft),
        .alu_iv_mov   (alu_iv_mov),
        .alu_opcode   (alu_opcode),
        .alu_cond     (alu_cond),
        .alu_s        (alu_s),
        .alu_flag     (alu_flag),
        .alu_result   (alu_result),
        .alu_new_flag (alu_new_flag),
        .flags        (flags),
        .done         (done),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational read, bench preload port has priority.
    logic [31:0] rf [16];
    logic        tb_we;
    logic [3:0]  tb_wa;
    logic [31:0] tb_wd;
    int          we_count;

    always @(posedge clk) begin
        if (tb_we) rf[tb_wa] <= tb_wd;
        else if (rf_we) rf[rf_waddr] <= rf_wdata;
    end

    always @(posedge clk) begin
        if (rf_we) we_count <= we_count + 1;
    end

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    // Behavioural ALU (ADD/SUB/CMP/MOV/MOVn are enough here).
    logic [32:0] sum;
    logic        ovf;
    always_comb begin
        sum        = 33'd0;
        ovf        = 1'b0;
        alu_result = 32'd0;
        case (alu_opcode)
            OP_ADD: begin
                sum        = {1'b0, alu_reg1} + {1'b0, alu_reg2};
                alu_result = sum[31:0];
                ovf = (alu_reg1[31] == alu_reg2[31]) &&
                      (alu_result[31] != alu_reg1[31]);
            end
            OP_SUB, OP_CMP: begin
                sum = {1'b0, alu_reg1} + {1'b0, ~alu_reg2} + 33'd1;
                alu_result = sum[31:0];
                ovf = (alu_reg1[31] != alu_reg2[31]) &&
                      (alu_result[31] != alu_reg1[31]);
            end
            OP_MOV:  alu_result = alu_reg2;
            OP_MOVN: alu_result = {16'd0, alu_iv_mov};
            default: alu_result = 32'd0;
        endcase
        alu_new_flag = {alu_result[31], (alu_result == 32'd0), sum[32], ovf};
    end

    int n_chk;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] cc,
                                        input logic [3:0] op,
                                        input logic s,
                                        input logic [3:0] rd,
                                        input logic [3:0] rn,
                                        input logic [3:0] rm);
        return {cc, op, s, rd, rn, rm, 5'd0, 6'd0};
    endfunction

    function automatic logic [31:0] encm(input logic [3:0] cc,
                                         input logic s,
                                         input logic [3:0] rd,
                                         input logic [15:0] imm);
        return {cc, OP_MOVN, s, rd, 3'b000, imm};
    endfunction

    task automatic set_reg(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issues one word, returns retire-cycle observations and flags after.
    task automatic issue(input logic [31:0] w, output logic we,
                         output logic ill, output logic [3:0] wa,
                         output logic [31:0] wd, output logic [3:0] fl,
                         output int lat);
        wait_ready();
        instr_valid = 1'b1;
        instr_data  = w;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        lat = -1;
        we  = 1'b0;
        ill = 1'b0;
        wa  = 4'd0;
        wd  = 32'd0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done) begin
                we  = rf_we;
                ill = illegal;
                wa  = rf_waddr;
                wd  = rf_wdata;
                lat = c;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        fl = flags;
    endtask

    logic        we, ill;
    logic [3:0]  wa, fl;
    logic [31:0] wd;
    int          lat;
    int          base;
    int          acc [3];
    int          k;
    int          rdy_low;
    logic [31:0] ws [3];

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        we_count    = 0;
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr_data  = 32'd0;
        tb_we       = 1'b0;
        tb_wa       = 4'd0;
        tb_wd       = 32'd0;

        set_reg(4'd6,  32'hDEAD_0006);
        set_reg(4'd12, 32'h1111_1111);
        set_reg(4'd13, 32'h2222_2222);
        set_reg(4'd14, 32'h3333_3333);
        @(negedge clk);
        check("rst_ready", instr_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_we", rf_we, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_flags", flags, 4'h0);
        check("rst_alu_cond", alu_cond, 4'h0);
        check("rst_alu_s", alu_s, 1'b0);
        check("rst_alu_flag", alu_flag, 4'h0);
        check("rst_shft", alu_iv_shft, 5'd0);
        check("rst_reg1", alu_reg1, 32'd0);
        reset_n = 1'b1;

        // ADD R3 = R1 + R2, S=1
        set_reg(4'd1, 32'd5);
        set_reg(4'd2, 32'd7);
        issue(enc(CC_AL, OP_ADD, 1'b1, 4'd3, 4'd1, 4'd2), we, ill, wa, wd, fl, lat);
        check("add_lat", lat, 2 + EC);
        check("add_we", we, 1'b1);
        check("add_waddr", wa, 4'd3);
        check("add_wdata", wd, 32'd12);
        check("add_flags", fl, 4'b0000);
        check("add_rf", rf[3], 32'd12);

        // SUB equal -> Z,C; EQ ADD executes
        set_reg(4'd1, 32'd9);
        set_reg(4'd2, 32'd9);
        issue(enc(CC_AL, OP_SUB, 1'b1, 4'd5, 4'd1, 4'd2), we, ill, wa, wd, fl, lat);
        check("sub_eq_wdata", wd, 32'd0);
        check("sub_eq_flags", fl, 4'b0110);
        issue(enc(CC_EQ, OP_ADD, 1'b0, 4'd3, 4'd1, 4'd2), we, ill, wa, wd, fl, lat);
        check("eq_add_we", we, 1'b1);
        check("eq_add_wdata", wd, 32'd18);
        check("eq_add_flags", fl, 4'b0110);

        // SUB unequal -> no Z; EQ ADD skipped
        set_reg(4'd2, 32'd4);
        issue(enc(CC_AL, OP_SUB, 1'b1, 4'd5, 4'd1, 4'd2), we, ill, wa, wd, fl, lat);
        check("sub_ne_wdata", wd, 32'd5);
        check("sub_ne_flags", fl, 4'b0010);
        base = we_count;
        issue(enc(CC_EQ, OP_ADD, 1'b0, 4'd3, 4'd1, 4'd2), we, ill, wa, wd, fl, lat);
        check("eq_skip_lat", lat, 2 + EC);
        check("eq_skip_we", we_count - base, 0);
        check("eq_skip_rf", rf[3], 32'd18);

        // CMP 3 - 8 -> N; LT executes, GE skipped
        set_reg(4'd1, 32'd3);
        set_reg(4'd2, 32'd8);
        base = we_count;
        issue(enc(CC_AL, OP_CMP, 1'b0, 4'd7, 4'd1, 4'd2), we, ill, wa, wd, fl, lat);
        check("cmp_we", we_count - base, 0);
        check("cmp_flags", fl, 4'b1000);
        issue(enc(CC_LT, OP_MOV, 1'b0, 4'd11, 4'd0, 4'd1), we, ill, wa, wd, fl, lat);
        check("lt_mov_we", we, 1'b1);
        check("lt_mov_wdata", wd, 32'd3);
        set_reg(4'd1, 32'd77);
        issue(enc(CC_GE, OP_MOV, 1'b0, 4'd11, 4'd0, 4'd1), we, ill, wa, wd, fl, lat);
        check("ge_mov_we", we, 1'b0);
        check("ge_mov_rf", rf[11], 32'd3);

        // MOVn with S=1 leaves flags alone
        issue(encm(CC_AL, 1'b1, 4'd4, 16'hBEEF), we, ill, wa, wd, fl, lat);
        check("movn_we", we, 1'b1);
        check("movn_waddr", wa, 4'd4);
        check("movn_wdata", wd, 32'h0000_BEEF);
        check("movn_flags", fl, 4'b1000);

        // Illegal opcode
        base = we_count;
        issue(enc(CC_AL, 4'b1101, 1'b1, 4'd6, 4'd1, 4'd2), we, ill, wa, wd, fl, lat);
        check("ill_pulse", ill, 1'b1);
        check("ill_lat", lat, 2 + EC);
        check("ill_we", we_count - base, 0);
        check("ill_flags", fl, 4'b1000);

        // Reset during EXEC aborts the instruction
        set_reg(4'd1, 32'd3);
        wait_ready();
        instr_valid = 1'b1;
        instr_data  = enc(CC_AL, OP_ADD, 1'b1, 4'd6, 4'd1, 4'd2);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        base    = we_count;
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("abort_ready", instr_ready, 1'b1);
        check("abort_flags", flags, 4'h0);
        check("abort_done", done, 1'b0);
        repeat (8) @(negedge clk);
        check("abort_we", we_count - base, 0);
        check("abort_rf", rf[6], 32'hDEAD_0006);

        // instr_valid held high: one accept every 2+EC+1 cycles
        ws[0] = enc(CC_AL, OP_MOV, 1'b0, 4'd8,  4'd0, 4'd12);
        ws[1] = enc(CC_AL, OP_MOV, 1'b0, 4'd9,  4'd0, 4'd13);
        ws[2] = enc(CC_AL, OP_MOV, 1'b0, 4'd10, 4'd0, 4'd14);
        base    = we_count;
        k       = 0;
        rdy_low = 0;
        for (int c = 0; c < 60 && k < 3; c++) begin
            @(negedge clk);
            if (instr_ready) begin
                instr_valid = 1'b1;
                instr_data  = ws[k];
                acc[k]      = c;
                k++;
            end else if (k > 0) begin
                rdy_low++;
            end
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        check("strm_accepts", k, 3);
        if (k == 3) begin
            check("strm_gap01", acc[1] - acc[0], 3 + EC);
            check("strm_gap12", acc[2] - acc[1], 3 + EC);
        end
        check("strm_rdy_low", rdy_low, 2 * (2 + EC));
        repeat (10) @(negedge clk);
        check("strm_we_cnt", we_count - base, 3);
        check("strm_r8", rf[8], 32'h1111_1111);
        check("strm_r9", rf[9], 32'h2222_2222);
        check("strm_r10", rf[10], 32'h3333_3333);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
